// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state codes, image framing
// constants and the word-count range check.
package prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_LEN  = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_DONE = 3'd3;
  localparam state_t S_ERR  = 3'd4;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // True when an image of n words would not fit in a 2^addr_w word memory.
  // Valid for addr_w up to 16, matching the 16-bit word count.
  function automatic logic len_too_big(input logic [15:0] n, input int addr_w);
    logic [16:0] depth;
    depth = 17'(1) << addr_w;
    return {1'b0, n} > depth;
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words; emits a one-cycle word_valid
// with the word captured into its own register so new bytes cannot disturb it.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_reg;
  logic [8*(BYTES_PER_WORD-1)-1:0] lanes;
  logic        word_valid_reg;
  logic [31:0] word_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg <= '0;
    end else if (clear) begin
      idx_reg <= '0;
    end else if (byte_valid) begin
      idx_reg <= idx_reg + IDX_W'(1);
    end
  end

  // The top byte never needs storage: it is taken straight from the input.
  for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
    logic [7:0] lane_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_reg <= '0;
      end else if (clear) begin
        lane_reg <= '0;
      end else if (byte_valid && idx_reg == IDX_W'(gi)) begin
        lane_reg <= byte_data;
      end
    end

    assign lanes[8*gi +: 8] = lane_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_valid_reg <= 1'b0;
      word_reg       <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      if (!clear && byte_valid && idx_reg == LAST_IDX) begin
        word_valid_reg <= 1'b1;
        word_reg       <= {byte_data, lanes};
      end
    end
  end

  assign word_valid = word_valid_reg;
  assign word_data  = word_reg;

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed little-endian program image from a UART byte stream
// into the instruction memory write port, holding the CPU in reset meanwhile.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic HDR_LAST = 1'(HDR_BYTES - 1);

  state_t            state_reg, state_next;
  logic              hdr_cnt_reg, hdr_cnt_next;
  logic [15:0]       n_reg, n_next;
  logic [15:0]       word_cnt_reg, word_cnt_next;
  logic [TMO_W-1:0]  tmo_cnt_reg, tmo_cnt_next;

  logic              in_load;
  logic              timeout_hit;
  logic              asm_clear;
  logic              asm_byte_valid;
  logic              word_valid;
  logic [31:0]       word_data;
  logic [15:0]       n_full;

  assign in_load        = (state_reg == S_LEN) || (state_reg == S_DATA);
  assign timeout_hit    = in_load && (tmo_cnt_reg == TMO_LAST);
  assign asm_byte_valid = rx_valid && (state_reg == S_DATA);
  assign n_full         = {rx_data, n_reg[7:0]};

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_byte_valid),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_next    = state_reg;
    hdr_cnt_next  = hdr_cnt_reg;
    n_next        = n_reg;
    word_cnt_next = word_cnt_reg;
    tmo_cnt_next  = '0;
    asm_clear     = 1'b0;

    if (in_load && !rx_valid) begin
      tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    end

    case (state_reg)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_next    = S_LEN;
          hdr_cnt_next  = 1'b0;
          n_next        = '0;
          word_cnt_next = '0;
          asm_clear     = 1'b1;
        end
      end
      S_LEN: begin
        if (timeout_hit) begin
          state_next = S_ERR;
          asm_clear  = 1'b1;
        end else if (rx_valid) begin
          if (hdr_cnt_reg != HDR_LAST) begin
            n_next[7:0]  = rx_data;
            hdr_cnt_next = hdr_cnt_reg + 1'b1;
          end else begin
            n_next = n_full;
            if (n_full == 16'd0) begin
              state_next = S_DONE;
            end else if (len_too_big(n_full, ADDR_W)) begin
              state_next = S_ERR;
              asm_clear  = 1'b1;
            end else begin
              state_next    = S_DATA;
              word_cnt_next = '0;
            end
          end
        end
      end
      S_DATA: begin
        if (word_valid) begin
          word_cnt_next = word_cnt_reg + 16'd1;
          if (word_cnt_reg == n_reg - 16'd1) begin
            state_next = S_DONE;
          end
        end else if (timeout_hit) begin
          state_next = S_ERR;
          asm_clear  = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      hdr_cnt_reg  <= 1'b0;
      n_reg        <= '0;
      word_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      hdr_cnt_reg  <= hdr_cnt_next;
      n_reg        <= n_next;
      word_cnt_reg <= word_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
    end
  end

  // The write only ever lands in DATA, so an abort can never leak a word out.
  assign mem_we    = word_valid && (state_reg == S_DATA);
  assign mem_addr  = word_cnt_reg[ADDR_W-1:0];
  assign mem_wdata = word_data;
  assign cpu_hold  = (state_reg != S_IDLE);
  assign busy      = in_load;
  assign done      = (state_reg == S_DONE);
  assign err       = (state_reg == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: normal loads, empty image,
// timeout abort, oversize header, back-to-back stream and async reset.
module tb_prog_loader;

  localparam int ADDR_W = 14;
  localparam int TMO    = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int done_count = 0;

  logic [31:0] exp_word [3];

  prog_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) we_count <= we_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step(1);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    exp_word[0] = 32'h04030201;
    exp_word[1] = 32'h14131211;
    exp_word[2] = 32'h24232221;

    // Reset state
    step(3);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    step(2);

    // rx in IDLE is ignored
    send(8'h55);
    chk("idle_rx_busy", busy, 0);
    chk("idle_rx_hold", cpu_hold, 0);

    // Two-word load
    pulse_start();
    chk("t1_hold_after_start", cpu_hold, 1);
    chk("t1_busy_len", busy, 1);
    send(8'h02); send(8'h00);
    chk("t1_busy_data", busy, 1);
    send(8'h13); send(8'h00); send(8'h00);
    chk("t1_no_we_early", mem_we, 0);
    send(8'h00);
    chk("t1_w0_we", mem_we, 1);
    chk("t1_w0_addr", mem_addr, 0);
    chk("t1_w0_data", mem_wdata, 32'h00000013);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    chk("t1_w1_we", mem_we, 1);
    chk("t1_w1_addr", mem_addr, 1);
    chk("t1_w1_data", mem_wdata, 32'h00100093);
    chk("t1_no_done_yet", done, 0);
    step(1);
    chk("t1_done", done, 1);
    chk("t1_hold_in_done", cpu_hold, 1);
    chk("t1_we_after", mem_we, 0);
    chk("t1_we_count", we_count, 2);
    step(1);
    chk("t1_done_low", done, 0);
    chk("t1_hold_released", cpu_hold, 0);
    chk("t1_done_count", done_count, 1);

    // Empty image
    pulse_start();
    send(8'h00); send(8'h00);
    chk("t2_done", done, 1);
    step(1);
    chk("t2_hold_released", cpu_hold, 0);
    chk("t2_done_count", done_count, 2);
    chk("t2_we_count", we_count, 2);

    // Timeout mid-word
    pulse_start();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    step(TMO - 1);
    chk("t3_err_before_limit", err, 0);
    chk("t3_busy_before_limit", busy, 1);
    step(1);
    chk("t3_err", err, 1);
    chk("t3_hold", cpu_hold, 1);
    chk("t3_busy", busy, 0);
    chk("t3_we_count", we_count, 2);
    send(8'h77);
    chk("t3_err_sticky", err, 1);
    step(1);
    chk("t3_no_we_in_err", we_count, 2);
    pulse_start();
    chk("t3_err_cleared", err, 0);
    chk("t3_busy_restart", busy, 1);
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 0);
    chk("t3_data", mem_wdata, 32'hDEADBEEF);
    step(1);
    chk("t3_done", done, 1);
    step(1);

    // Oversize header N = 16385
    pulse_start();
    send(8'h01); send(8'h40);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    step(2);
    chk("t4_we_count", we_count, 3);

    // Back-to-back N=3 from ERR, with an ignored start mid-load
    pulse_start();
    chk("t5_err_cleared", err, 0);
    send(8'h03); send(8'h00);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (w == 1 && k == 1) start = 1'b1;
        send(8'((w << 4) + k + 1));
        start = 1'b0;
      end
      chk($sformatf("t5_w%0d_we", w), mem_we, 1);
      chk($sformatf("t5_w%0d_addr", w), mem_addr, w);
      chk($sformatf("t5_w%0d_data", w), mem_wdata, exp_word[w]);
    end
    step(1);
    chk("t5_done", done, 1);
    chk("t5_we_count", we_count, 6);
    step(1);
    chk("t5_hold_released", cpu_hold, 0);

    // N = 16384 accepted, then async reset mid-DATA
    pulse_start();
    send(8'h00); send(8'h40);
    chk("t6_busy_max_n", busy, 1);
    chk("t6_no_err_max_n", err, 0);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    chk("t6_we", mem_we, 1);
    chk("t6_addr", mem_addr, 0);
    chk("t6_data", mem_wdata, 32'h88776655);
    send(8'h99); send(8'hAA);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_mem_we", mem_we, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_mem_wdata", mem_wdata, 0);
    chk("t6_rst_cpu_hold", cpu_hold, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("t6_idle_hold", cpu_hold, 0);
    chk("t6_idle_busy", busy, 0);
    pulse_start();
    chk("t6_restart_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writes program words into the instruction ROM's write port from a byte stream delivered by the UART receiver.
- It is the writer side of the instruction memory that the fetch unit reads through a word address (pc[15:2]).
- While a load is in progress it holds the CPU in reset, so fetch never sees a partially written image.
- Image format: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian.

Parameters:
- ADDR_W, 14, word-address width of the instruction memory. Depth is 2^ADDR_W words.
- TIMEOUT_CYC, 1000000, maximum idle clocks between bytes before the load aborts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- rx_data  in  8  received byte
- mem_we  out  1  instruction memory write enable, one-cycle pulse
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  word to write
- cpu_hold  out  1  high means the CPU is held in reset
- busy  out  1  high while in LEN or DATA
- done  out  1  one-cycle pulse when a load completes successfully
- err  out  1  sticky abort flag

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All outputs 0; mem_addr=0; mem_wdata=0.
  - Byte counter, word counter and timeout counter cleared.
  - A reset mid-load abandons the load immediately; memory contents already written are left as they are.
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE:
  - cpu_hold=0. rx_valid is ignored.
  - start -> LEN; clear counters and err; cpu_hold=1 from the next cycle.
- LEN:
  - First rx_valid byte -> N[7:0]; second -> N[15:8].
  - On the second byte: N==0 -> DONE; N>2^ADDR_W -> ERR; otherwise -> DATA with word index 0.
- DATA:
  - Byte k of a word (k=0..3) goes into assembly register bits [8k+7:8k].
  - On the 4th byte, in the next cycle: mem_we=1 for exactly one cycle, mem_addr=word index, mem_wdata=assembled word. The word index then increments.
  - Write latency is 1 clock after the 4th rx_valid.
  - A new rx_valid arriving in the same cycle as mem_we is accepted into a fresh assembly; it must not corrupt mem_wdata. The write data is captured separately from the assembly register.
  - After the write of word N-1 -> DONE.
- DONE:
  - Lasts one cycle: done=1; cpu_hold=0 in the following cycle.
  - -> IDLE.
- Timeout:
  - In LEN or DATA, the counter resets on every rx_valid and increments otherwise.
  - Reaching TIMEOUT_CYC-1 -> ERR.
- ERR:
  - err=1 and cpu_hold=1 are held.
  - No writes. start -> LEN, which clears err.
- Other rules:
  - start is ignored in LEN, DATA and DONE.
  - rx_valid in DONE or ERR is dropped.
  - busy = (state is LEN or DATA).
  - The word counter is 16 bits wide; mem_addr is its low ADDR_W bits. The N check above guarantees no wrap.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/LEN/DATA/DONE/ERR)
  - the header length constant HDR_BYTES=2
  - BYTES_PER_WORD=4
- One natural sub-module, word_assembler:
  - shifts in bytes little-endian.
  - outputs a word_valid pulse plus the word.
  - has a clear input used by start and by ERR.
- The FSM, counters and timeout stay in prog_loader.

Test Plan:
- Reset then start; send bytes 02 00 13 00 00 00 93 00 10 00 -> mem_we at addr 0 data 0x00000013, then addr 1 data 0x00100093. Each write 1 cycle after its 4th byte. done pulses once; cpu_hold high from start+1 until the cycle after done.
- start, then send 00 00 -> no mem_we, done pulses, cpu_hold released.
- start, then 01 00 AA BB, then silence for TIMEOUT_CYC clocks -> ERR: err=1, cpu_hold=1, no mem_we. A new start clears err and a subsequent valid load succeeds.
- Header 01 40 (N=16385 > 16384) with ADDR_W=14 -> ERR immediately after the second byte; no writes.
- Back-to-back rx_valid every cycle for N=3 -> three writes at addr 0, 1, 2 with correct data; the byte arriving in the mem_we cycle is not lost. A start pulse mid-load is ignored.
- Assert rst low mid-DATA -> all outputs 0 asynchronously; after release, state is IDLE and cpu_hold=0.
